// File: rtl/acc_sysreg_file.sv
// Accumulator file (16 x 32) plus eight system registers: status/flags, free-running
// cycle, retire and accumulator-write counters, two scratch registers and a constant ID.
module acc_sysreg_file (
   input  logic        clk_i_arf,
   input  logic        rst_i_arf,
   input  logic [4:0]  acc_wen_vctr_i_arf,
   input  logic [31:0] acc_wdata_i_arf,
   input  logic        sys_wen_i_arf,
   input  logic [2:0]  sys_waddr_i_arf,
   input  logic [31:0] sys_wdata_i_arf,
   input  logic        cc_wen_i_arf,
   input  logic [1:0]  rslt_cc_i_arf,
   input  logic        retire_i_arf,
   output logic [31:0] acc00_o_arf,
   output logic [31:0] acc01_o_arf,
   output logic [31:0] acc02_o_arf,
   output logic [31:0] acc03_o_arf,
   output logic [31:0] acc04_o_arf,
   output logic [31:0] acc05_o_arf,
   output logic [31:0] acc06_o_arf,
   output logic [31:0] acc07_o_arf,
   output logic [31:0] acc08_o_arf,
   output logic [31:0] acc09_o_arf,
   output logic [31:0] acc10_o_arf,
   output logic [31:0] acc11_o_arf,
   output logic [31:0] acc12_o_arf,
   output logic [31:0] acc13_o_arf,
   output logic [31:0] acc14_o_arf,
   output logic [31:0] acc15_o_arf,
   output logic [31:0] sysreg00_o_arf,
   output logic [31:0] sysreg01_o_arf,
   output logic [31:0] sysreg02_o_arf,
   output logic [31:0] sysreg03_o_arf,
   output logic [31:0] sysreg04_o_arf,
   output logic [31:0] sysreg05_o_arf,
   output logic [31:0] sysreg06_o_arf,
   output logic [31:0] sysreg07_o_arf
);

   localparam logic [2:0]  AddrStatus  = 3'd0;
   localparam logic [2:0]  AddrCycLo   = 3'd1;
   localparam logic [2:0]  AddrCycHi   = 3'd2;
   localparam logic [2:0]  AddrRetire  = 3'd3;
   localparam logic [2:0]  AddrScr0    = 3'd4;
   localparam logic [2:0]  AddrScr1    = 3'd5;
   localparam logic [2:0]  AddrAccWr   = 3'd6;
   localparam logic [31:0] IdValue     = 32'h0000_0001;

   logic [31:0] acc_q [16];
   logic        zero_q, zero_d;
   logic        ovf_q, ovf_d;
   logic        sticky_q, sticky_d;
   logic        cen_q, cen_d;
   logic [31:0] cyc_lo_q, cyc_lo_d;
   logic [31:0] cyc_hi_q, cyc_hi_d;
   logic [31:0] retire_q, retire_d;
   logic [31:0] scr0_q, scr0_d;
   logic [31:0] scr1_q, scr1_d;
   logic [31:0] accwr_q, accwr_d;

   logic acc_we;
   logic wr_status, wr_cyc_lo, wr_cyc_hi, wr_retire, wr_scr0, wr_scr1, wr_accwr;
   logic lo_carry;

   assign acc_we    = acc_wen_vctr_i_arf[4];
   assign wr_status = sys_wen_i_arf && (sys_waddr_i_arf == AddrStatus);
   assign wr_cyc_lo = sys_wen_i_arf && (sys_waddr_i_arf == AddrCycLo);
   assign wr_cyc_hi = sys_wen_i_arf && (sys_waddr_i_arf == AddrCycHi);
   assign wr_retire = sys_wen_i_arf && (sys_waddr_i_arf == AddrRetire);
   assign wr_scr0   = sys_wen_i_arf && (sys_waddr_i_arf == AddrScr0);
   assign wr_scr1   = sys_wen_i_arf && (sys_waddr_i_arf == AddrScr1);
   assign wr_accwr  = sys_wen_i_arf && (sys_waddr_i_arf == AddrAccWr);

   // A software write to CYCLE_LO swallows the carry that would otherwise ripple into HI.
   assign lo_carry = cen_q && (cyc_lo_q == 32'hFFFF_FFFF) && !wr_cyc_lo;

   always_comb begin
      zero_d   = zero_q;
      ovf_d    = ovf_q;
      sticky_d = sticky_q;
      cen_d    = cen_q;
      if (wr_status) begin
         cen_d = sys_wdata_i_arf[8];
         if (!sys_wdata_i_arf[2]) sticky_d = 1'b0;
      end
      if (cc_wen_i_arf) begin
         zero_d = rslt_cc_i_arf[0];
         ovf_d  = rslt_cc_i_arf[1];
         if (rslt_cc_i_arf[1]) sticky_d = 1'b1;
      end
   end

   // Counters advance on the CEN in effect before this edge, so a STATUS write lands late.
   always_comb begin
      cyc_lo_d = wr_cyc_lo ? sys_wdata_i_arf : cyc_lo_q + {31'd0, cen_q};
      cyc_hi_d = wr_cyc_hi ? sys_wdata_i_arf : cyc_hi_q + {31'd0, lo_carry};
      retire_d = wr_retire ? sys_wdata_i_arf : retire_q + {31'd0, cen_q && retire_i_arf};
      accwr_d  = wr_accwr  ? sys_wdata_i_arf : accwr_q + {31'd0, cen_q && acc_we};
      scr0_d   = wr_scr0   ? sys_wdata_i_arf : scr0_q;
      scr1_d   = wr_scr1   ? sys_wdata_i_arf : scr1_q;
   end

   always_ff @(posedge clk_i_arf) begin
      if (rst_i_arf) begin
         for (int i = 0; i < 16; i++) acc_q[i] <= '0;
      end else if (acc_we) begin
         acc_q[acc_wen_vctr_i_arf[3:0]] <= acc_wdata_i_arf;
      end
   end

   always_ff @(posedge clk_i_arf) begin
      if (rst_i_arf) begin
         zero_q   <= 1'b0;
         ovf_q    <= 1'b0;
         sticky_q <= 1'b0;
         cen_q    <= 1'b1;
         cyc_lo_q <= '0;
         cyc_hi_q <= '0;
         retire_q <= '0;
         scr0_q   <= '0;
         scr1_q   <= '0;
         accwr_q  <= '0;
      end else begin
         zero_q   <= zero_d;
         ovf_q    <= ovf_d;
         sticky_q <= sticky_d;
         cen_q    <= cen_d;
         cyc_lo_q <= cyc_lo_d;
         cyc_hi_q <= cyc_hi_d;
         retire_q <= retire_d;
         scr0_q   <= scr0_d;
         scr1_q   <= scr1_d;
         accwr_q  <= accwr_d;
      end
   end

   assign acc00_o_arf = acc_q[0];
   assign acc01_o_arf = acc_q[1];
   assign acc02_o_arf = acc_q[2];
   assign acc03_o_arf = acc_q[3];
   assign acc04_o_arf = acc_q[4];
   assign acc05_o_arf = acc_q[5];
   assign acc06_o_arf = acc_q[6];
   assign acc07_o_arf = acc_q[7];
   assign acc08_o_arf = acc_q[8];
   assign acc09_o_arf = acc_q[9];
   assign acc10_o_arf = acc_q[10];
   assign acc11_o_arf = acc_q[11];
   assign acc12_o_arf = acc_q[12];
   assign acc13_o_arf = acc_q[13];
   assign acc14_o_arf = acc_q[14];
   assign acc15_o_arf = acc_q[15];

   assign sysreg00_o_arf = {23'd0, cen_q, 5'd0, sticky_q, ovf_q, zero_q};
   assign sysreg01_o_arf = cyc_lo_q;
   assign sysreg02_o_arf = cyc_hi_q;
   assign sysreg03_o_arf = retire_q;
   assign sysreg04_o_arf = scr0_q;
   assign sysreg05_o_arf = scr1_q;
   assign sysreg06_o_arf = accwr_q;
   assign sysreg07_o_arf = IdValue;

endmodule
